// File: rtl/regfile_scoreboard.sv
// Write-back architectural state: 32x32 GPR file, four machine CSRs, same-cycle
// commit bypass and a per-register in-flight scoreboard that stalls decode.
module regfile_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wena_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        csr_wena_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        dec_valid_i,
    input  logic        rs1_used_i,
    input  logic        rs2_used_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        csr_used_i,
    input  logic [31:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        issue_wena_i,
    input  logic [4:0]  issue_waddr_i,
    input  logic        issue_csr_wena_i,
    input  logic        flush_i,
    output logic        stall_o
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CntMax = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CntOne = CW'(1);

    localparam logic [31:0] AddrMstatus  = 32'h0000_0300;
    localparam logic [31:0] AddrMtvec    = 32'h0000_0305;
    localparam logic [31:0] AddrMepc     = 32'h0000_0341;
    localparam logic [31:0] AddrMcause   = 32'h0000_0342;
    localparam logic [31:0] MstatusReset = 32'h0000_1800;

    function automatic logic csrValid(input logic [31:0] addr);
        return (addr == AddrMstatus) || (addr == AddrMtvec) ||
               (addr == AddrMepc)    || (addr == AddrMcause);
    endfunction

    logic [31:0]   gprQ [32];
    logic [31:0]   mstatusQ, mtvecQ, mepcQ, mcauseQ;
    logic [CW-1:0] cntQ [32];
    logic [CW-1:0] cntD [32];
    logic [CW-1:0] ccntQ, ccntD;

    logic          gprCommit;
    logic          issue;
    logic [31:0]   incVec, decVec;
    logic          cInc, cDec;
    logic [31:0]   csrArray;
    logic          csrBypass;
    logic [CW-1:0] cnt1, cnt2, cntIss;
    logic          hit1, hit2, hitIss;
    logic          busy1, busy2, cbusy, gprFull, csrFull;

    assign gprCommit = wena_i && (waddr_i != 5'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                gprQ[r] <= '0;
            end
        end else if (gprCommit) begin
            gprQ[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatusQ <= MstatusReset;
            mtvecQ   <= '0;
            mepcQ    <= '0;
            mcauseQ  <= '0;
        end else if (csr_wena_i) begin
            case (csr_waddr_i)
                AddrMstatus: mstatusQ <= csr_wdata_i;
                AddrMtvec:   mtvecQ   <= csr_wdata_i;
                AddrMepc:    mepcQ    <= csr_wdata_i;
                AddrMcause:  mcauseQ  <= csr_wdata_i;
                default:     ;
            endcase
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 :
                      (gprCommit && (waddr_i == raddr1_i)) ? wdata_i : gprQ[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 :
                      (gprCommit && (waddr_i == raddr2_i)) ? wdata_i : gprQ[raddr2_i];

    always_comb begin
        csrArray = '0;
        case (csr_raddr_i)
            AddrMstatus: csrArray = mstatusQ;
            AddrMtvec:   csrArray = mtvecQ;
            AddrMepc:    csrArray = mepcQ;
            AddrMcause:  csrArray = mcauseQ;
            default:     csrArray = '0;
        endcase
    end

    // Bypass only to real CSRs so unmapped addresses always read as zero.
    assign csrBypass   = csr_wena_i && (csr_waddr_i == csr_raddr_i) && csrValid(csr_raddr_i);
    assign csr_rdata_o = csrBypass ? csr_wdata_i : csrArray;

    assign cnt1   = cntQ[raddr1_i];
    assign cnt2   = cntQ[raddr2_i];
    assign cntIss = cntQ[issue_waddr_i];
    assign hit1   = gprCommit && (waddr_i == raddr1_i);
    assign hit2   = gprCommit && (waddr_i == raddr2_i);
    assign hitIss = gprCommit && (waddr_i == issue_waddr_i);

    // A register whose last pending write commits now is served by the bypass.
    assign busy1 = (raddr1_i != 5'd0) && (cnt1 != '0) && !((cnt1 == CntOne) && hit1);
    assign busy2 = (raddr2_i != 5'd0) && (cnt2 != '0) && !((cnt2 == CntOne) && hit2);
    assign cbusy = (ccntQ != '0) && !((ccntQ == CntOne) && csr_wena_i);

    // Fullness uses the post-commit count so a same-cycle commit frees a slot.
    assign gprFull = issue_wena_i && (issue_waddr_i != 5'd0) &&
                     (cntIss == CntMax) && !hitIss;
    assign csrFull = issue_csr_wena_i && (ccntQ == CntMax) && !csr_wena_i;

    assign stall_o = dec_valid_i && ((rs1_used_i && busy1) || (rs2_used_i && busy2) ||
                                     (csr_used_i && cbusy) || gprFull || csrFull);

    assign issue  = dec_valid_i && !stall_o;
    assign incVec = (issue && issue_wena_i && (issue_waddr_i != 5'd0)) ?
                    (32'd1 << issue_waddr_i) : 32'd0;
    assign decVec = gprCommit ? (32'd1 << waddr_i) : 32'd0;
    assign cInc   = issue && issue_csr_wena_i;
    assign cDec   = csr_wena_i;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cntD[r] = cntQ[r];
            if (flush_i) begin
                cntD[r] = '0;
            end else if (incVec[r] && !decVec[r]) begin
                cntD[r] = cntQ[r] + CntOne;
            end else if (decVec[r] && !incVec[r] && (cntQ[r] != '0)) begin
                cntD[r] = cntQ[r] - CntOne;
            end
        end
        ccntD = ccntQ;
        if (flush_i) begin
            ccntD = '0;
        end else if (cInc && !cDec) begin
            ccntD = ccntQ + CntOne;
        end else if (cDec && !cInc && (ccntQ != '0)) begin
            ccntD = ccntQ - CntOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cntQ[r] <= '0;
            end
            ccntQ <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cntQ[r] <= cntD[r];
            end
            ccntQ <= ccntD;
        end
    end

    // A commit with nothing pending means the pipeline lost track of a write.
    always_ff @(posedge clock) begin
        if (!reset && !flush_i) begin
            assert (!(gprCommit && !incVec[waddr_i] && (cntQ[waddr_i] == '0)));
            assert (!(cDec && !cInc && (ccntQ == '0)));
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, RAW stall, overflow, CSR, flush and reset.
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wenaI, csrWenaI, decValidI, rs1UsedI, rs2UsedI, csrUsedI;
    logic        issueWenaI, issueCsrWenaI, flushI;
    logic [4:0]  waddrI, raddr1I, raddr2I, issueWaddrI;
    logic [31:0] wdataI, csrWaddrI, csrWdataI, csrRaddrI;
    logic [31:0] rdata1O, rdata2O, csrRdataO;
    logic        stallO;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clock(clock), .reset(reset),
        .wena_i(wenaI), .waddr_i(waddrI), .wdata_i(wdataI),
        .csr_wena_i(csrWenaI), .csr_waddr_i(csrWaddrI), .csr_wdata_i(csrWdataI),
        .dec_valid_i(decValidI), .rs1_used_i(rs1UsedI), .rs2_used_i(rs2UsedI),
        .raddr1_i(raddr1I), .raddr2_i(raddr2I),
        .rdata1_o(rdata1O), .rdata2_o(rdata2O),
        .csr_used_i(csrUsedI), .csr_raddr_i(csrRaddrI), .csr_rdata_o(csrRdataO),
        .issue_wena_i(issueWenaI), .issue_waddr_i(issueWaddrI),
        .issue_csr_wena_i(issueCsrWenaI), .flush_i(flushI), .stall_o(stallO)
    );

    // Every cycle starts at the falling edge with all inputs idle.
    task automatic applyStimulus();
        @(negedge clock);
        wenaI = 0; waddrI = 0; wdataI = 0;
        csrWenaI = 0; csrWaddrI = 0; csrWdataI = 0;
        decValidI = 0; rs1UsedI = 0; rs2UsedI = 0; raddr1I = 0; raddr2I = 0;
        csrUsedI = 0; csrRaddrI = 0;
        issueWenaI = 0; issueWaddrI = 0; issueCsrWenaI = 0; flushI = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        applyStimulus();
        applyStimulus();
        reset = 0;
        raddr1I = 5; csrRaddrI = 32'h300;
        #1;
        checks++; if (rdata1O !== 32'd0) begin errors++; $display("[TB] FAIL reset_x5: got %h expected %h", rdata1O, 32'd0); end
        checks++; if (csrRdataO !== 32'h1800) begin errors++; $display("[TB] FAIL reset_mstatus: got %h expected %h", csrRdataO, 32'h1800); end
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stallO); end
    endtask

    task automatic test_write_bypass();
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 3;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL issue_x3_stall: got %b expected 0", stallO); end
        applyStimulus();
        wenaI = 1; waddrI = 3; wdataI = 32'hDEAD_BEEF; raddr1I = 3;
        #1;
        checks++; if (rdata1O !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bypass_x3: got %h expected %h", rdata1O, 32'hDEAD_BEEF); end
        applyStimulus();
        raddr1I = 3;
        #1;
        checks++; if (rdata1O !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL array_x3: got %h expected %h", rdata1O, 32'hDEAD_BEEF); end
        applyStimulus();
        wenaI = 1; waddrI = 0; wdataI = 5; raddr2I = 0;
        #1;
        checks++; if (rdata2O !== 32'd0) begin errors++; $display("[TB] FAIL x0_bypass: got %h expected 0", rdata2O); end
        applyStimulus();
        raddr1I = 0;
        #1;
        checks++; if (rdata1O !== 32'd0) begin errors++; $display("[TB] FAIL x0_read: got %h expected 0", rdata1O); end
    endtask

    task automatic test_raw_stall();
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 7;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL issue_x7_stall: got %b expected 0", stallO); end
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            decValidI = 1; rs1UsedI = 1; raddr1I = 7;
            #1;
            checks++; if (stallO !== 1'b1) begin errors++; $display("[TB] FAIL raw_wait_%0d: got %b expected 1", i, stallO); end
        end
        applyStimulus();
        decValidI = 1; rs1UsedI = 1; raddr1I = 7;
        wenaI = 1; waddrI = 7; wdataI = 32'h1234_5678;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL raw_release: got %b expected 0", stallO); end
        checks++; if (rdata1O !== 32'h1234_5678) begin errors++; $display("[TB] FAIL raw_bypass: got %h expected %h", rdata1O, 32'h1234_5678); end
        applyStimulus();
        decValidI = 1; rs1UsedI = 1; raddr1I = 7;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL raw_after: got %b expected 0", stallO); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            decValidI = 1; issueWenaI = 1; issueWaddrI = 4;
            #1;
            checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL ovf_issue_%0d: got %b expected 0", i, stallO); end
        end
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 4;
        #1;
        checks++; if (stallO !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %b expected 1", stallO); end
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 4;
        wenaI = 1; waddrI = 4; wdataI = 32'h44;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL ovf_commit_frees: got %b expected 0", stallO); end
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 4;
        #1;
        checks++; if (stallO !== 1'b1) begin errors++; $display("[TB] FAIL ovf_still_3: got %b expected 1", stallO); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            wenaI = 1; waddrI = 4; wdataI = 32'h100 + i;
        end
        applyStimulus();
        decValidI = 1; rs1UsedI = 1; raddr1I = 4;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", stallO); end
        checks++; if (rdata1O !== 32'h102) begin errors++; $display("[TB] FAIL ovf_x4_data: got %h expected %h", rdata1O, 32'h102); end
    endtask

    task automatic test_csr();
        applyStimulus();
        decValidI = 1; issueCsrWenaI = 1;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL csr_issue: got %b expected 0", stallO); end
        applyStimulus();
        decValidI = 1; csrUsedI = 1; csrRaddrI = 32'h341;
        #1;
        checks++; if (stallO !== 1'b1) begin errors++; $display("[TB] FAIL csr_busy: got %b expected 1", stallO); end
        applyStimulus();
        decValidI = 1; csrUsedI = 1; csrRaddrI = 32'h341;
        csrWenaI = 1; csrWaddrI = 32'h341; csrWdataI = 32'h8000_0010;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL csr_release: got %b expected 0", stallO); end
        checks++; if (csrRdataO !== 32'h8000_0010) begin errors++; $display("[TB] FAIL csr_bypass: got %h expected %h", csrRdataO, 32'h8000_0010); end
        applyStimulus();
        csrRaddrI = 32'h341;
        #1;
        checks++; if (csrRdataO !== 32'h8000_0010) begin errors++; $display("[TB] FAIL csr_mepc: got %h expected %h", csrRdataO, 32'h8000_0010); end
        applyStimulus();
        decValidI = 1; issueCsrWenaI = 1;
        applyStimulus();
        csrWenaI = 1; csrWaddrI = 32'h7C0; csrWdataI = 32'hFFFF_FFFF;
        applyStimulus();
        csrRaddrI = 32'h7C0;
        #1;
        checks++; if (csrRdataO !== 32'd0) begin errors++; $display("[TB] FAIL csr_unmapped: got %h expected 0", csrRdataO); end
        csrRaddrI = 32'h300;
        #1;
        checks++; if (csrRdataO !== 32'h1800) begin errors++; $display("[TB] FAIL csr_mstatus_kept: got %h expected %h", csrRdataO, 32'h1800); end
    endtask

    task automatic test_flush();
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 9;
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 10;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue10: got %b expected 0", stallO); end
        applyStimulus();
        decValidI = 1; rs2UsedI = 1; raddr2I = 10;
        #1;
        checks++; if (stallO !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", stallO); end
        applyStimulus();
        flushI = 1;
        applyStimulus();
        decValidI = 1; rs1UsedI = 1; raddr1I = 9; rs2UsedI = 1; raddr2I = 10;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL flush_cleared: got %b expected 0", stallO); end
    endtask

    task automatic test_reset_mid();
        applyStimulus();
        decValidI = 1; issueWenaI = 1; issueWaddrI = 12;
        applyStimulus();
        decValidI = 1; issueCsrWenaI = 1;
        applyStimulus();
        reset = 1;
        applyStimulus();
        reset = 0;
        decValidI = 1; rs1UsedI = 1; raddr1I = 12; csrUsedI = 1; csrRaddrI = 32'h341; raddr2I = 3;
        #1;
        checks++; if (stallO !== 1'b0) begin errors++; $display("[TB] FAIL rst_counts: got %b expected 0", stallO); end
        checks++; if (rdata2O !== 32'd0) begin errors++; $display("[TB] FAIL rst_x3: got %h expected 0", rdata2O); end
        checks++; if (csrRdataO !== 32'd0) begin errors++; $display("[TB] FAIL rst_mepc: got %h expected 0", csrRdataO); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_raw_stall();
        test_overflow();
        test_csr();
        test_flush();
        test_reset_mid();
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
